// File: rtl/vga_pkg.sv
// Shared 640x480 @ 60 Hz raster timing constants and the coordinate type.
package vga_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef logic [9:0] vga_coord_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrap counter with terminal count and a registered active-low
// sync flag that is derived from the counter's next value.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int TOTAL      = 800,
   parameter int SYNC_START = 656,
   parameter int SYNC_END   = 751,
   parameter int RST_VAL    = 799
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       en,
   output vga_coord_t cnt,
   output vga_coord_t cnt_nxt,
   output logic       tc,
   output logic       sync_n
);

   localparam vga_coord_t LAST = vga_coord_t'(TOTAL - 1);
   localparam vga_coord_t S0   = vga_coord_t'(SYNC_START);
   localparam vga_coord_t S1   = vga_coord_t'(SYNC_END);
   localparam vga_coord_t RV   = vga_coord_t'(RST_VAL);
   localparam logic SYNC_RST   = !(RST_VAL >= SYNC_START && RST_VAL <= SYNC_END);

   assign tc = (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (en) cnt_nxt = tc ? '0 : cnt + 10'd1;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= RV;
         sync_n <= SYNC_RST;
      end else if (en) begin
         cnt    <= cnt_nxt;
         sync_n <= !(cnt_nxt >= S0 && cnt_nxt <= S1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Define VGA_SYNC_ALIGN_EN to delay hs/vs by one
// pixel so they line up with the renderers' registered colour.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       pix_en,
   output vga_coord_t DrawX,
   output vga_coord_t DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic       line_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam vga_coord_t HV = vga_coord_t'(H_VISIBLE);
   localparam vga_coord_t VV = vga_coord_t'(V_VISIBLE);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
         $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
      end
   endgenerate

   vga_coord_t hc_nxt, vc_nxt;
   logic       h_tc, v_tc, h_sync_n, v_sync_n;

   vga_axis_cnt #(
      .TOTAL(H_TOTAL), .SYNC_START(H_VISIBLE + H_FP),
      .SYNC_END(H_VISIBLE + H_FP + H_SYNC - 1), .RST_VAL(H_TOTAL - 1)
   ) u_hcnt (
      .vga_clk(vga_clk), .reset_n(reset_n), .en(pix_en),
      .cnt(DrawX), .cnt_nxt(hc_nxt), .tc(h_tc), .sync_n(h_sync_n)
   );

   // Vertical axis only steps on the horizontal wrap, so both wrap on one edge.
   vga_axis_cnt #(
      .TOTAL(V_TOTAL), .SYNC_START(V_VISIBLE + V_FP),
      .SYNC_END(V_VISIBLE + V_FP + V_SYNC - 1), .RST_VAL(V_TOTAL - 1)
   ) u_vcnt (
      .vga_clk(vga_clk), .reset_n(reset_n), .en(pix_en & h_tc),
      .cnt(DrawY), .cnt_nxt(vc_nxt), .tc(v_tc), .sync_n(v_sync_n)
   );

   // The next position is (0,0) / column 0 exactly when the current one is a terminal count.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         blank       <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else if (pix_en) begin
         blank       <= (hc_nxt < HV) && (vc_nxt < VV);
         frame_start <= h_tc & v_tc;
         line_start  <= h_tc;
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hs <= 1'b1;
         vs <= 1'b1;
      end else if (pix_en) begin
         hs <= h_sync_n;
         vs <= v_sync_n;
      end
   end
`else
   assign hs = h_sync_n;
   assign vs = v_sync_n;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench: a full-size instance and a shrunken-timing
// instance are both compared every cycle against a raster-index model.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   logic pix_en  = 1'b0;

   logic [9:0] dx_d, dy_d, dx_s, dy_s;
   logic bl_d, hs_d, vs_d, fs_d, ls_d;
   logic bl_s, hs_s, vs_s, fs_s, ls_s;

   int checks = 0;
   int errors = 0;
   int n = 0;      // qualified edges since reset release

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen dut_d (
      .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
      .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d), .hs(hs_d), .vs(vs_d),
      .frame_start(fs_d), .line_start(ls_d)
   );

   vga_timing_gen #(
      .H_VISIBLE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
      .V_VISIBLE(12), .V_FP(3), .V_SYNC(2), .V_BP(4)
   ) dut_s (
      .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
      .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s), .hs(hs_s), .vs(vs_s),
      .frame_start(fs_s), .line_start(ls_s)
   );

   wire [24:0] obs_d = {dx_d, dy_d, bl_d, hs_d, vs_d, fs_d, ls_d};
   wire [24:0] obs_s = {dx_s, dy_s, bl_s, hs_s, vs_s, fs_s, ls_s};

   // Position after n pixel advances from the reset position (last pixel of the frame).
   function automatic logic [24:0] model(input int hv, hf, hsy, hb, vv, vf, vsy, vb, input int k);
      int ht, vt, ft, p, q, x, y, qx, qy;
      logic b, h, v, f, l;
      ht = hv + hf + hsy + hb;
      vt = vv + vf + vsy + vb;
      ft = ht * vt;
      p  = (ft - 1 + k) % ft;
      x  = p % ht;
      y  = p / ht;
      b  = (x < hv) && (y < vv);
      f  = (p == 0);
      l  = (x == 0);
      q  = p;
      if (ALIGN) q = (p + ft - 1) % ft;
      qx = q % ht;
      qy = q / ht;
      h  = !(qx >= hv + hf && qx < hv + hf + hsy);
      v  = !(qy >= vv + vf && qy < vv + vf + vsy);
      if (ALIGN && k == 0) begin
         h = 1'b1;
         v = 1'b1;
      end
      return {10'(x), 10'(y), b, h, v, f, l};
   endfunction

   function automatic logic [24:0] exp_d(input int k);
      return model(640, 16, 96, 48, 480, 10, 2, 33, k);
   endfunction

   function automatic logic [24:0] exp_s(input int k);
      return model(20, 4, 6, 5, 12, 3, 2, 4, k);
   endfunction

   task automatic tick(input logic pe);
      pix_en = pe;
      @(posedge vga_clk);
      if (pe && reset_n) n++;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         checks++;
         if (obs_d !== exp_d(0) || obs_d !== {10'd799, 10'd524, 5'b01100}) begin
            errors++;
            $display("FAIL reset_d got %h exp %h", obs_d, exp_d(0));
         end
         checks++;
         if (obs_s !== exp_s(0)) begin
            errors++;
            $display("FAIL reset_s got %h exp %h", obs_s, exp_s(0));
         end
      end
      reset_n = 1'b1;
      tick(1'b1);
      checks++;
      if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL first_edge got %h exp %h", obs_d, {10'd0, 10'd0, 5'b11111});
      end
   endtask

   task automatic test_line_scan();
      int hs_low, ls_cnt, fall_x;
      hs_low = 0; ls_cnt = 0; fall_x = -1;
      for (int i = 0; i < 1600; i++) begin
         tick(1'b1);
         checks++;
         if (obs_d !== exp_d(n)) begin
            errors++;
            $display("FAIL line_d n=%0d got %h exp %h", n, obs_d, exp_d(n));
         end
         if (i < 800 && !hs_d) hs_low++;
         if (ls_d) ls_cnt++;
         if (i < 800 && !bl_d && fall_x < 0) fall_x = int'(dx_d);
      end
      checks++;
      if (hs_low !== 96) begin
         errors++;
         $display("FAIL hs_width got %0d exp 96", hs_low);
      end
      checks++;
      if (ls_cnt !== 2) begin
         errors++;
         $display("FAIL line_start_count got %0d exp 2", ls_cnt);
      end
      checks++;
      if (fall_x !== 640) begin
         errors++;
         $display("FAIL blank_fall got %0d exp 640", fall_x);
      end
   endtask

   task automatic test_frame_scan();
      int fs_cnt, vs_low;
      fs_cnt = 0; vs_low = 0;
      for (int i = 0; i < 2 * 735; i++) begin
         tick(1'b1);
         checks++;
         if (obs_s !== exp_s(n)) begin
            errors++;
            $display("FAIL frame_s n=%0d got %h exp %h", n, obs_s, exp_s(n));
         end
         if (fs_s) fs_cnt++;
         if (i < 735 && !vs_s) vs_low++;
      end
      checks++;
      if (fs_cnt !== 2) begin
         errors++;
         $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
      end
      checks++;
      if (vs_low !== 70) begin
         errors++;
         $display("FAIL vs_width got %0d exp 70", vs_low);
      end
   endtask

   task automatic test_pix_en();
      logic pe;
      for (int i = 0; i < 1800; i++) begin
         pe = (i < 300) ? logic'(i % 2 == 0) : logic'($urandom_range(0, 2) != 0);
         tick(pe);
         checks++;
         if (obs_s !== exp_s(n)) begin
            errors++;
            $display("FAIL pix_en_s n=%0d got %h exp %h", n, obs_s, exp_s(n));
         end
         checks++;
         if (obs_d !== exp_d(n)) begin
            errors++;
            $display("FAIL pix_en_d n=%0d got %h exp %h", n, obs_d, exp_d(n));
         end
      end
   endtask

   task automatic test_mid_reset();
      int run;
      for (int r = 0; r < 3; r++) begin
         run = $urandom_range(100, 900);
         for (int i = 0; i < run; i++) tick(1'b1);
         #2 reset_n = 1'b0;
         #1;
         n = 0;
         checks++;
         if (obs_d !== exp_d(0)) begin
            errors++;
            $display("FAIL async_reset_d got %h exp %h", obs_d, exp_d(0));
         end
         checks++;
         if (obs_s !== exp_s(0)) begin
            errors++;
            $display("FAIL async_reset_s got %h exp %h", obs_s, exp_s(0));
         end
         tick(1'b1);
         reset_n = 1'b1;
         for (int i = 0; i < 40; i++) begin
            tick(1'b1);
            checks++;
            if (obs_s !== exp_s(n) || obs_d !== exp_d(n)) begin
               errors++;
               $display("FAIL restart n=%0d got %h/%h exp %h/%h",
                        n, obs_d, obs_s, exp_d(n), exp_s(n));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_scan();
      test_frame_scan();
      test_pix_en();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
